// File: rtl/cs_pkg.sv
// cs_pkg: shared constants and types for the CS computational system.
//   CS_DATA_W : width of one CS result word Y.
//   CS_WINDOW : length of the sample window feeding the CS result stream.
//   CS_SKIP   : warm-up results produced before the window is full.
//   cs_word_t : one CS result word.
package cs_pkg;

  localparam int CS_DATA_W = 10;
  localparam int CS_WINDOW = 9;
  localparam int CS_SKIP   = CS_WINDOW - 1;

  typedef logic [CS_DATA_W-1:0] cs_word_t;

endpackage

// File: rtl/cs_fifo_core.sv
// cs_fifo_core: first-word-fall-through FIFO storage for cs_result_buffer.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset.
//   wr_en / wr_data  : write request and word; ignored when full unless a
//                      read happens in the same cycle.
//   rd_en            : advance the head; ignored when empty.
//   rd_data          : word at the read pointer (the FIFO head).
//   count            : occupancy 0..DEPTH.
//   full / empty     : occupancy flags derived from count.
module cs_fifo_core
  import cs_pkg::*;
#(
  parameter int DATA_W = CS_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // A write into a full FIFO is legal only when the head is read in the
  // same cycle: wptr equals rptr then, so the slot being freed is reused.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Storage is cleared on reset so the head reads 0 until the first write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rd_data = mem[rptr];
  assign count   = cnt;

endmodule

// File: rtl/cs_result_buffer.sv
// cs_result_buffer: downstream stage of the CS computational system.
// Drops the warm-up results produced while the sample window fills, buffers
// valid results in a FWFT FIFO and hands them out with valid/ready.
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset.
//   in_valid / in_data   : incoming CS result Y.
//   out_valid / out_data : FIFO head; out_ready accepts it.
//   count                : FIFO occupancy 0..DEPTH.
//   warm                 : warm-up done, results are being stored.
//   overflow             : sticky, a result was dropped while full.
// Optional (macro CS_STATS_EN): stat_min / stat_max over all stored words.
module cs_result_buffer
  import cs_pkg::*;
#(
  parameter int DATA_W = CS_DATA_W,
  parameter int DEPTH  = 8,
  parameter int SKIP   = CS_SKIP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   warm,
`ifdef CS_STATS_EN
  output logic [DATA_W-1:0]      stat_min,
  output logic [DATA_W-1:0]      stat_max,
`endif
  output logic                   overflow
);

  localparam int SKIP_W = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

  logic [SKIP_W-1:0] skip_cnt;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              store;

  // The skip counter only counts while still warming up, so it saturates
  // at SKIP; with SKIP=0 it is already warm straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_cnt <= '0;
    end else if (in_valid && !warm) begin
      skip_cnt <= skip_cnt + 1'b1;
    end
  end

  assign warm  = (skip_cnt == SKIP_W'(SKIP));
  assign push  = in_valid & warm;
  assign pop   = out_valid & out_ready;
  assign store = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  cs_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // count is a register, so out_valid carries no combinational input path.
  assign out_valid = ~empty;

`ifdef CS_STATS_EN
  // Only words actually stored count toward the statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_min <= '1;
      stat_max <= '0;
    end else if (store) begin
      if (in_data < stat_min) stat_min <= in_data;
      if (in_data > stat_max) stat_max <= in_data;
    end
  end
`endif

endmodule
